// File: rtl/huff_seq_ctrl.sv
// rtl/huff_seq_ctrl.sv - phase sequencer in front of the Huffman encoder
//   clock, reset                          rising-edge clock, async active-high reset
//   cmd_start                             begin a block (honoured in IDLE only)
//   in_valid/in_ready, in_sym, in_last    symbol collection from the pins
//   tbl_valid/tbl_ready, tbl_idx, tbl_cnt histogram stream to the tree builder
//   build_go, build_done                  tree build pulse / completion
//   enc_valid/enc_ready, enc_sym, enc_last symbol replay to the encoder
//   enc_idle                              encoder has flushed its output
//   busy, done, trunc, phase              status
module huff_seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sym,
  input  logic             in_last,
  output logic             tbl_valid,
  input  logic             tbl_ready,
  output logic [3:0]       tbl_idx,
  output logic [CNT_W-1:0] tbl_cnt,
  output logic             build_go,
  input  logic             build_done,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic [3:0]       enc_sym,
  output logic             enc_last,
  input  logic             enc_idle,
  output logic             busy,
  output logic             done,
  output logic             trunc,
  output logic [2:0]       phase
);

  // One extra pointer bit so the write count can reach DEPTH itself.
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_TABLE   = 3'd2;
  localparam logic [2:0] S_BUILD   = 3'd3;
  localparam logic [2:0] S_ENCODE  = 3'd4;
  localparam logic [2:0] S_FLUSH   = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [PTR_W-1:0]       wr_q, wr_d;
  logic [PTR_W-1:0]       rd_q, rd_d;
  logic [3:0]             idx_q, idx_d;
  logic                   go_sent_q, go_sent_d;
  logic                   trunc_q, trunc_d;
  logic [15:0][CNT_W-1:0] hist_q, hist_d;
  logic [3:0]             sym_mem [DEPTH];
  logic                   mem_we;
  logic                   in_fire;

  assign in_fire = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    idx_d     = idx_q;
    go_sent_d = go_sent_q;
    trunc_d   = trunc_q;
    hist_d    = hist_q;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        hist_d    = '0;
        wr_d      = '0;
        rd_d      = '0;
        idx_d     = '0;
        go_sent_d = 1'b0;
        if (cmd_start) begin
          state_d = S_COLLECT;
          trunc_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (in_fire) begin
          mem_we = 1'b1;
          wr_d   = wr_q + PTR_W'(1);
          if (hist_q[in_sym] != {CNT_W{1'b1}})
            hist_d[in_sym] = hist_q[in_sym] + CNT_W'(1);
          if (in_last) begin
            state_d = S_TABLE;
          end else if (wr_q == PTR_W'(DEPTH - 1)) begin
            // Buffer filled without an end marker: the block was cut short.
            state_d = S_TABLE;
            trunc_d = 1'b1;
          end
        end
      end
      S_TABLE: begin
        if (tbl_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15)
            state_d = S_BUILD;
        end
      end
      S_BUILD: begin
        go_sent_d = 1'b1;
        // build_done seen in the build_go cycle itself is accepted.
        if (build_done) begin
          state_d   = S_ENCODE;
          go_sent_d = 1'b0;
          rd_d      = '0;
        end
      end
      S_ENCODE: begin
        if (enc_ready) begin
          if (rd_q == wr_q - PTR_W'(1))
            state_d = S_FLUSH;
          else
            rd_d = rd_q + PTR_W'(1);
        end
      end
      S_FLUSH: begin
        if (enc_idle)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      idx_q     <= '0;
      go_sent_q <= 1'b0;
      trunc_q   <= 1'b0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      idx_q     <= idx_d;
      go_sent_q <= go_sent_d;
      trunc_q   <= trunc_d;
      hist_q    <= hist_d;
    end
  end

  // Symbol storage needs no reset: it is only read below the write count.
  always_ff @(posedge clock) begin
    if (mem_we)
      sym_mem[wr_q[AW-1:0]] <= in_sym;
  end

  // All valids/readys are pure state decodes; data is gated to zero outside its phase.
  assign in_ready  = (state_q == S_COLLECT) && (wr_q < PTR_W'(DEPTH));
  assign tbl_valid = (state_q == S_TABLE);
  assign tbl_idx   = idx_q;
  assign tbl_cnt   = tbl_valid ? hist_q[idx_q] : '0;
  assign build_go  = (state_q == S_BUILD) && !go_sent_q;
  assign enc_valid = (state_q == S_ENCODE);
  assign enc_sym   = enc_valid ? sym_mem[rd_q[AW-1:0]] : 4'd0;
  assign enc_last  = enc_valid && (rd_q == wr_q - PTR_W'(1));
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FLUSH) && enc_idle;
  assign trunc     = trunc_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// tb/tb_huff_seq_ctrl.sv - self-checking bench for huff_seq_ctrl
module tb_huff_seq_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, cmd_start, in_valid, in_last, tbl_ready, build_done, enc_ready, enc_idle;
  logic [3:0] in_sym;
  logic       in_ready, tbl_valid, build_go, enc_valid, enc_last, busy, done, trunc;
  logic [3:0] tbl_idx, enc_sym;
  logic [4:0] tbl_cnt;
  logic [2:0] phase;

  logic       s_in_ready, s_tbl_valid, s_build_go, s_enc_valid, s_enc_last, s_busy, s_done, s_trunc;
  logic [3:0] s_tbl_idx, s_enc_sym;
  logic [2:0] s_tbl_cnt;
  logic [2:0] s_phase;

  huff_seq_ctrl #(.DEPTH(16), .CNT_W(5)) u_dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .tbl_valid(tbl_valid), .tbl_ready(tbl_ready), .tbl_idx(tbl_idx), .tbl_cnt(tbl_cnt),
    .build_go(build_go), .build_done(build_done),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_sym(enc_sym), .enc_last(enc_last),
    .enc_idle(enc_idle), .busy(busy), .done(done), .trunc(trunc), .phase(phase)
  );

  huff_seq_ctrl #(.DEPTH(16), .CNT_W(3)) u_sat (
    .clock(clock), .reset(reset), .cmd_start(cmd_start),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_sym(in_sym), .in_last(in_last),
    .tbl_valid(s_tbl_valid), .tbl_ready(tbl_ready), .tbl_idx(s_tbl_idx), .tbl_cnt(s_tbl_cnt),
    .build_go(s_build_go), .build_done(build_done),
    .enc_valid(s_enc_valid), .enc_ready(enc_ready), .enc_sym(s_enc_sym), .enc_last(s_enc_last),
    .enc_idle(enc_idle), .busy(s_busy), .done(s_done), .trunc(s_trunc), .phase(s_phase)
  );

  typedef struct {
    logic       cs, iv, il, tr, bd, er, ei;
    logic [3:0] isym;
    logic [2:0] ph;
    logic       ir, tv;
    logic [3:0] ti;
    logic [4:0] tc;
    logic [2:0] tc3;
    logic       bg, ev;
    logic [3:0] es;
    logic       el, dn, tk;
  } vec_t;

  vec_t       vq[$];
  logic [3:0] syms_g [16];
  logic       prev_tk;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] act_vec();
    return {phase, in_ready, tbl_valid, tbl_idx, tbl_cnt, s_tbl_cnt, build_go,
            enc_valid, enc_sym, enc_last, done, trunc, busy};
  endfunction

  task automatic drive_idle();
    cmd_start = 0; in_valid = 0; in_sym = 0; in_last = 0;
    tbl_ready = 0; build_done = 0; enc_ready = 0; enc_idle = 0;
  endtask

  // Expected per-cycle records for a block run with every handshake ready.
  task automatic gen_block(input int n, input bit has_last, input int flush_wait);
    int   h[16];
    vec_t v;
    for (int i = 0; i < 16; i++) h[i] = 0;
    v = '{default: 0}; v.cs = 1; v.tk = prev_tk; vq.push_back(v);
    for (int i = 0; i < n; i++) begin
      v = '{default: 0};
      v.ph = 3'd1; v.ir = 1; v.iv = 1; v.isym = syms_g[i];
      v.il = has_last && (i == n - 1);
      vq.push_back(v);
      h[syms_g[i]]++;
    end
    prev_tk = !has_last;
    for (int i = 0; i < 16; i++) begin
      v = '{default: 0};
      v.ph = 3'd2; v.tv = 1; v.tr = 1; v.ti = 4'(i); v.tc = 5'(h[i]);
      v.tc3 = (h[i] > 7) ? 3'd7 : 3'(h[i]); v.tk = prev_tk;
      vq.push_back(v);
    end
    v = '{default: 0}; v.ph = 3'd3; v.bg = 1; v.bd = 1; v.tk = prev_tk; vq.push_back(v);
    for (int i = 0; i < n; i++) begin
      v = '{default: 0};
      v.ph = 3'd4; v.ev = 1; v.er = 1; v.es = syms_g[i]; v.el = (i == n - 1); v.tk = prev_tk;
      vq.push_back(v);
    end
    for (int w = 0; w < flush_wait; w++) begin
      v = '{default: 0}; v.ph = 3'd5; v.tk = prev_tk; vq.push_back(v);
    end
    v = '{default: 0}; v.ph = 3'd5; v.ei = 1; v.dn = 1; v.tk = prev_tk; vq.push_back(v);
  endtask

  task automatic push_idle();
    vec_t v;
    v = '{default: 0}; v.tk = prev_tk; vq.push_back(v);
  endtask

  task automatic apply_all(input string tag, input int n);
    int lim;
    lim = (n <= 0) ? vq.size() : n;
    for (int i = 0; i < lim; i++) begin
      vec_t v;
      logic [26:0] exp;
      v = vq[i];
      cmd_start = v.cs; in_valid = v.iv; in_sym = v.isym; in_last = v.il;
      tbl_ready = v.tr; build_done = v.bd; enc_ready = v.er; enc_idle = v.ei;
      #1;
      exp = {v.ph, v.ir, v.tv, v.ti, v.tc, v.tc3, v.bg, v.ev, v.es, v.el, v.dn, v.tk, (v.ph != 3'd0)};
      chk($sformatf("%s_v%0d", tag, i), 32'(act_vec()), 32'(exp));
      @(posedge clock); #1;
    end
    vq.delete();
    drive_idle();
  endtask

  initial begin
    int eh[16];
    int eidx, rd, go_cnt, bcyc;
    bit bd_seen, fin;
    logic [2:0] ep;

    drive_idle();
    prev_tk = 0;
    reset = 1;
    #1;
    chk("reset_state", 32'(act_vec()), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 0;

    // Basic block 3,3,7,0 with in_last on 0.
    syms_g[0] = 4'd3; syms_g[1] = 4'd3; syms_g[2] = 4'd7; syms_g[3] = 4'd0;
    gen_block(4, 1, 0);
    // Full buffer of fives, no in_last.
    for (int i = 0; i < 16; i++) syms_g[i] = 4'd5;
    gen_block(16, 0, 0);
    // Sixteen nines: saturates the narrow-counter instance.
    for (int i = 0; i < 16; i++) syms_g[i] = 4'd9;
    gen_block(16, 0, 0);
    // Single-symbol block with enc_idle late.
    syms_g[0] = 4'hF;
    gen_block(1, 1, 2);
    push_idle();
    apply_all("tbl", 0);

    // Backpressure on the table and replay, delayed build_done.
    syms_g[0] = 4'd1; syms_g[1] = 4'd4; syms_g[2] = 4'd4; syms_g[3] = 4'd9;
    for (int i = 0; i < 16; i++) eh[i] = 0;
    for (int i = 0; i < 4; i++) eh[syms_g[i]]++;
    cmd_start = 1;
    @(posedge clock); #1;
    cmd_start = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sym = syms_g[i]; in_last = (i == 3);
      @(posedge clock); #1;
    end
    drive_idle();
    eidx = 0; rd = 0; go_cnt = 0; bcyc = 0; bd_seen = 0; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      ep = (eidx < 16) ? 3'd2 : (!bd_seen) ? 3'd3 : (rd < 4) ? 3'd4 : 3'd5;
      tbl_ready  = 1'($urandom_range(0, 1));
      enc_ready  = 1'($urandom_range(0, 1));
      build_done = (ep == 3'd3) && (bcyc >= 10);
      cmd_start  = (ep == 3'd4);
      enc_idle   = 1;
      #1;
      chk("bp_phase", 32'(phase), 32'(ep));
      case (ep)
        3'd2: begin
          chk("bp_tbl", 32'({tbl_valid, tbl_idx, tbl_cnt}), 32'({1'b1, 4'(eidx), 5'(eh[eidx])}));
          if (tbl_ready) eidx++;
        end
        3'd3: begin
          if (build_go) go_cnt++;
          if (build_done) bd_seen = 1;
          bcyc++;
        end
        3'd4: begin
          chk("bp_enc", 32'({enc_valid, enc_sym, enc_last}), 32'({1'b1, syms_g[rd], (rd == 3)}));
          if (enc_ready) rd++;
        end
        default: begin
          chk("bp_done", 32'(done), 32'd1);
          fin = 1;
        end
      endcase
      @(posedge clock); #1;
    end
    drive_idle();
    chk("bp_finished", 32'(fin), 32'd1);
    chk("bp_build_go_count", 32'(go_cnt), 32'd1);
    #1;
    chk("bp_back_idle", 32'({phase, busy, trunc}), 32'd0);

    // Reset in ENCODE after 2 of 4 symbols replayed.
    syms_g[0] = 4'd2; syms_g[1] = 4'd5; syms_g[2] = 4'd5; syms_g[3] = 4'd8;
    gen_block(4, 1, 0);
    apply_all("pre_rst", 24);
    chk("pre_rst_in_encode", 32'(phase), 32'd4);
    #2;
    reset = 1;
    #1;
    chk("rst_mid_async", 32'(act_vec()), 32'd0);
    @(posedge clock); #1;
    chk("rst_mid_held", 32'(act_vec()), 32'd0);
    reset = 0;
    prev_tk = 0;
    syms_g[0] = 4'd1; syms_g[1] = 4'd2;
    gen_block(2, 1, 0);
    push_idle();
    apply_all("post_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
